// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry register, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             overflow
`else
    output logic             cout
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // Full-adder cell: two cascaded half-add stages, carries merged by an OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c, carry_next;

    always_comb begin
        ha1_s      = a_sh_q[0] ^ b_sh_q[0];
        ha1_c      = a_sh_q[0] & b_sh_q[0];
        ha2_s      = ha1_s ^ carry_q;
        ha2_c      = ha1_s & carry_q;
        carry_next = ha1_c | ha2_c;
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    assign overflow = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        a_sh_q     <= a;
                        b_sh_q     <= b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StShift;
                    end else begin
                        // Also raises in_ready on the first cycle after reset.
                        in_ready_q <= 1'b1;
                    end
                end
                StShift: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    sum_sh_q <= {ha2_s, sum_sh_q[WIDTH-1:1]};
                    carry_q  <= carry_next;
                    cout_q   <= carry_next;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB on this edge.
                        ovf_q       <= carry_q ^ carry_next;
`endif
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_sh_q;
    assign cout      = cout_q;

endmodule
